// File: rtl/sirv_gnrl_xchk_sched_pkg.sv
// Shared defaults and helpers for the X-check scheduler.
package sirv_gnrl_xchk_sched_pkg;

  localparam int XCHK_N  = 4;
  localparam int XCHK_DW = 32;
  localparam int XCHK_CW = 16;

  // Index width for v entries; callers guarantee v >= 2.
  function automatic int xchk_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sirv_gnrl_rr_arb.sv
// Combinational N-way round-robin picker: first eligible index scanning up from ptr, wrapping.
module sirv_gnrl_rr_arb #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx
);

  always_comb begin : pick
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && elig[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = SW'(j);
      end
    end
  end

endmodule

// File: rtl/sirv_gnrl_xchk_sched.sv
// Round-robin scheduler sharing one X-value checker between N requesters,
// with a single registered output stage and a saturating issued-check counter.
module sirv_gnrl_xchk_sched
  import sirv_gnrl_xchk_sched_pkg::*;
#(
  parameter int  N  = XCHK_N,
  parameter int  DW = XCHK_DW,
  parameter int  CW = XCHK_CW,
  localparam int SW = xchk_clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_en,
  input  logic [N-1:0]  i_req_vld,
  output logic [N-1:0]  i_req_rdy,
  input  logic [N*DW-1:0] i_req_dat,
  input  logic          i_clr,
  output logic          o_chk_vld,
  input  logic          o_chk_rdy,
  output logic [DW-1:0] o_chk_dat,
  output logic [SW-1:0] o_chk_src,
  output logic [CW-1:0] o_cnt,
  output logic          o_busy
);

  logic [N-1:0]  elig;
  logic [N-1:0]  grant;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] ptr;
  logic [DW-1:0] sel_dat;
  logic          load_en;
  logic          accept;

  assign elig    = i_req_vld & i_en;
  assign load_en = !o_chk_vld | o_chk_rdy;
  // Gate with rst_n so no requester sees ready while the block is held in reset.
  assign i_req_rdy = grant & {N{load_en & rst_n}};
  assign accept    = |i_req_rdy;
  assign o_busy    = o_chk_vld | (|elig);

  sirv_gnrl_rr_arb #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .elig  (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) sel_dat = i_req_dat[k*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_chk_vld <= 1'b0;
      o_chk_dat <= '0;
      o_chk_src <= '0;
    end else if (load_en) begin
      if (accept) begin
        o_chk_vld <= 1'b1;
        o_chk_dat <= sel_dat;
        o_chk_src <= gnt_idx;
      end else begin
        o_chk_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (i_clr) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (o_chk_vld && o_chk_rdy && (o_cnt != {CW{1'b1}})) begin
      o_cnt <= o_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_sirv_gnrl_xchk_sched.sv
// Self-checking bench for sirv_gnrl_xchk_sched (N=4, DW=32, CW=4) against a cycle-level behavioural model.
module tb_sirv_gnrl_xchk_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  en;
  logic [N-1:0]  vld;
  logic [N-1:0]  rdy;
  logic [N*DW-1:0] dat;
  logic          clr;
  logic          chk_vld;
  logic          chk_rdy;
  logic [DW-1:0] chk_dat;
  logic [1:0]    chk_src;
  logic [CW-1:0] cnt;
  logic          busy;

  int n_cmp;
  int n_err;

  // model state
  bit          m_vld;
  logic [31:0] m_dat;
  int          m_src;
  int          m_ptr;
  int          m_cnt;

  sirv_gnrl_xchk_sched #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (en),
    .i_req_vld (vld),
    .i_req_rdy (rdy),
    .i_req_dat (dat),
    .i_clr     (clr),
    .o_chk_vld (chk_vld),
    .o_chk_rdy (chk_rdy),
    .o_chk_dat (chk_dat),
    .o_chk_src (chk_src),
    .o_cnt     (cnt),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] e, input int p);
    for (int i = 0; i < N; i++) begin
      if (e[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    int g;
    g = pick(vld & en, m_ptr);
    if ((!m_vld || chk_rdy) && g >= 0) return N'(1 << g);
    return '0;
  endfunction

  function automatic logic exp_busy();
    return m_vld | (|(vld & en));
  endfunction

  task automatic set_word(input int k, input logic [31:0] w);
    dat[k*DW +: DW] = w;
  endtask

  task automatic model_reset();
    m_vld = 0; m_dat = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then step the DUT.
  task automatic tick();
    int  g;
    bit  load, acc;
    g    = pick(vld & en, m_ptr);
    load = !m_vld || chk_rdy;
    acc  = load && g >= 0;
    if (clr) m_cnt = 0;
    else if (m_vld && chk_rdy && m_cnt < CMAX) m_cnt++;
    if (clr) m_ptr = 0;
    else if (acc) m_ptr = (g + 1) % N;
    if (load) begin
      if (acc) begin
        m_vld = 1; m_dat = dat[g*DW +: DW]; m_src = g;
      end else begin
        m_vld = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vld = '0; en = '1; clr = 0; chk_rdy = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    vld = '1;
    for (int k = 0; k < N; k++) set_word(k, 32'h1000_0000 + k);
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (rdy !== '0 || chk_vld !== 1'b0 || chk_dat !== '0 || chk_src !== '0 || cnt !== '0) begin
      n_err++;
      $display("FAIL reset_state rdy=%b vld=%b dat=%h src=%0d cnt=%0d, want all 0", rdy, chk_vld, chk_dat, chk_src, cnt);
    end
    rst_n = 1;
    vld = '0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || rdy !== '0 || cnt !== '0) begin
      n_err++;
      $display("FAIL idle_after_reset busy=%b rdy=%b cnt=%0d, want 0/0000/0", busy, rdy, cnt);
    end
    tick();
    // load a word, then pull reset mid-cycle
    vld = 4'b0100;
    tick();
    n_cmp++;
    if (chk_vld !== 1'b1 || chk_src !== 2'd2) begin
      n_err++;
      $display("FAIL pre_reset_load vld=%b src=%0d, want 1/2", chk_vld, chk_src);
    end
    chk_rdy = 0;
    #3;
    rst_n = 0;
    #1;
    n_cmp++;
    if (chk_vld !== 1'b0 || chk_dat !== '0 || chk_src !== '0 || rdy !== '0 || cnt !== '0) begin
      n_err++;
      $display("FAIL async_reset vld=%b dat=%h src=%0d rdy=%b cnt=%0d, want zeros", chk_vld, chk_dat, chk_src, rdy, cnt);
    end
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    n_cmp++;
    if (cnt !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_discard cnt=%0d busy=%b, want 0/0", cnt, busy);
    end
  endtask

  task automatic test_single();
    idle_inputs();
    vld = 4'b0100;
    set_word(2, 32'hDEAD_BEEF);
    #1;
    n_cmp++;
    if (rdy !== 4'b0100) begin
      n_err++;
      $display("FAIL single_rdy got=%b want=0100", rdy);
    end
    tick();
    vld = '0;
    #1;
    n_cmp++;
    if (chk_vld !== 1'b1 || chk_dat !== 32'hDEAD_BEEF || chk_src !== 2'd2) begin
      n_err++;
      $display("FAIL single_out vld=%b dat=%h src=%0d, want 1/deadbeef/2", chk_vld, chk_dat, chk_src);
    end
    tick();
    n_cmp++;
    if (cnt !== 4'd1 || chk_vld !== 1'b0) begin
      n_err++;
      $display("FAIL single_cnt cnt=%0d vld=%b, want 1/0", cnt, chk_vld);
    end
    // ptr now 3: src3 wins over src2
    vld = 4'b1100;
    #1;
    n_cmp++;
    if (rdy !== 4'b1000) begin
      n_err++;
      $display("FAIL single_ptr rdy=%b want=1000", rdy);
    end
    tick();
    vld = '0;
    tick();
  endtask

  task automatic test_all_valid();
    idle_inputs();
    clr = 1;
    tick();
    clr = 1;
    tick();
    clr = 0;
    vld = '1;
    for (int k = 0; k < N; k++) set_word(k, 32'hA000_0000 + k);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (chk_vld !== 1'b1 || int'(chk_src) != i % N || chk_dat !== 32'hA000_0000 + (i % N)) begin
        n_err++;
        $display("FAIL rr_seq[%0d] vld=%b src=%0d dat=%h, want src %0d", i, chk_vld, chk_src, chk_dat, i % N);
      end
    end
    vld = '0;
    tick();
    n_cmp++;
    if (int'(cnt) != m_cnt || m_cnt != 6) begin
      n_err++;
      $display("FAIL rr_cnt got=%0d want=6", cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    idle_inputs();
    clr = 1;
    tick();
    clr = 0;
    vld = 4'b0010;
    set_word(1, 32'h5151_5151);
    tick();
    chk_rdy = 0;
    vld = 4'b1001;
    set_word(0, 32'h0000_0F0F);
    set_word(3, 32'h3333_3333);
    held = chk_dat;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (rdy !== '0 || chk_vld !== 1'b1 || chk_dat !== 32'h5151_5151 || chk_src !== 2'd1 || chk_dat !== held) begin
        n_err++;
        $display("FAIL stall[%0d] rdy=%b vld=%b dat=%h src=%0d, want 0000/1/51515151/1", i, rdy, chk_vld, chk_dat, chk_src);
      end
      tick();
    end
    chk_rdy = 1;
    #1;
    n_cmp++;
    if (rdy !== 4'b1000) begin
      n_err++;
      $display("FAIL drain_rdy got=%b want=1000", rdy);
    end
    tick();
    n_cmp++;
    if (chk_vld !== 1'b1 || chk_src !== 2'd3 || chk_dat !== 32'h3333_3333) begin
      n_err++;
      $display("FAIL drain_load vld=%b src=%0d dat=%h, want 1/3/33333333", chk_vld, chk_src, chk_dat);
    end
    vld = '0;
    tick();
    tick();
  endtask

  task automatic test_mask();
    int last;
    idle_inputs();
    en = 4'b1010;
    vld = '1;
    last = -1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if (rdy[0] !== 1'b0 || rdy[2] !== 1'b0 || rdy !== exp_rdy()) begin
        n_err++;
        $display("FAIL mask_rdy[%0d] got=%b want=%b", i, rdy, exp_rdy());
      end
      tick();
      n_cmp++;
      if ((chk_src !== 2'd1 && chk_src !== 2'd3) || int'(chk_src) == last) begin
        n_err++;
        $display("FAIL mask_src[%0d] got=%0d prev=%0d, want alternating 1/3", i, chk_src, last);
      end
      last = int'(chk_src);
    end
    vld = '0;
    en = '1;
    tick();
  endtask

  task automatic test_sat_clear();
    logic [31:0] held;
    idle_inputs();
    clr = 1;
    tick();
    clr = 0;
    vld = '1;
    for (int k = 0; k < N; k++) set_word(k, $urandom);
    repeat (21) tick();
    n_cmp++;
    if (cnt !== 4'd15 || m_cnt != CMAX) begin
      n_err++;
      $display("FAIL saturate got=%0d want=15", cnt);
    end
    // clear while a word is held under backpressure
    chk_rdy = 0;
    clr = 1;
    held = chk_dat;
    tick();
    n_cmp++;
    if (cnt !== '0 || chk_vld !== 1'b1 || chk_dat !== held) begin
      n_err++;
      $display("FAIL clr_hold cnt=%0d vld=%b dat=%h, want 0/1/%h", cnt, chk_vld, chk_dat, held);
    end
    // clear concurrent with a handshake and an accept: ptr back to 0
    chk_rdy = 1;
    vld = 4'b1101;
    tick();
    clr = 0;
    n_cmp++;
    if (cnt !== '0 || chk_vld !== 1'b1 || chk_src !== 2'(m_src)) begin
      n_err++;
      $display("FAIL clr_hs cnt=%0d vld=%b src=%0d, want 0/1/%0d", cnt, chk_vld, chk_src, m_src);
    end
    vld = '1;
    #1;
    n_cmp++;
    if (rdy !== 4'b0001) begin
      n_err++;
      $display("FAIL clr_ptr rdy=%b want=0001", rdy);
    end
    tick();
    vld = '0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      vld = 4'($urandom);
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '1;
      chk_rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < N; k++) set_word(k, $urandom);
      #1;
      n_cmp++;
      if (rdy !== exp_rdy() || busy !== exp_busy() || chk_vld !== m_vld || chk_dat !== m_dat ||
          int'(chk_src) != m_src || int'(cnt) != m_cnt) begin
        n_err++;
        $display("FAIL rand[%0d] rdy=%b/%b busy=%b/%b vld=%b/%b dat=%h/%h src=%0d/%0d cnt=%0d/%0d (got/want)",
                 i, rdy, exp_rdy(), busy, exp_busy(), chk_vld, m_vld, chk_dat, m_dat, chk_src, m_src, cnt, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    dat = '0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_mask();
    test_sat_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
